// File: rtl/branch_rs_bank.sv
// Branch-unit reservation station bank: ENTRIES slots filled from dispatch,
// operands captured from CDB_PORTS result buses, oldest ready slot issued
// through a valid/accept handshake. Flushed by reset or committed mispredict.
module branch_rs_bank #(
   parameter int WIDTH     = 31,
   parameter int ROB       = 2,
   parameter int C_WIDTH   = 7,
   parameter int ENTRIES   = 4,
   parameter int CDB_PORTS = 2
) (
   input  logic                              clk,
   input  logic                              globalReset,
   input  logic                              clear,
   input  logic                              validCommit,
   input  logic                              writeReq,
   input  logic                              ready1,
   input  logic                              ready2,
   input  logic signed [WIDTH:0]             value1,
   input  logic signed [WIDTH:0]             value2,
   input  logic [ROB:0]                      rob1,
   input  logic [ROB:0]                      rob2,
   input  logic [ROB:0]                      robInstr,
   input  logic [C_WIDTH:0]                  branchControl,
   input  logic [WIDTH:0]                    predictedPC,
   input  logic [WIDTH:0]                    address,
   input  logic [WIDTH:0]                    seqPC,
   input  logic [CDB_PORTS-1:0]              cdbValid,
   input  logic [CDB_PORTS*(ROB+1)-1:0]      cdbRob,
   input  logic [CDB_PORTS*(WIDTH+1)-1:0]    cdbResult,
   input  logic                              issueAccept,
   output logic                              issueValid,
   output logic [ROB:0]                      issueRob,
   output logic [C_WIDTH:0]                  issueInfo,
   output logic signed [WIDTH:0]             issueSrc1,
   output logic signed [WIDTH:0]             issueSrc2,
   output logic [WIDTH:0]                    issuePredicted,
   output logic [WIDTH:0]                    issueTarget,
   output logic [WIDTH:0]                    issueSeq,
   output logic                              full,
   output logic [$clog2(ENTRIES+1)-1:0]      count
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int CNT_W = $clog2(ENTRIES+1);

   logic [ENTRIES-1:0]      r_busy;
   logic [ENTRIES-1:0]      r_rdy1;
   logic [ENTRIES-1:0]      r_rdy2;
   logic signed [WIDTH:0]   r_val1  [ENTRIES];
   logic signed [WIDTH:0]   r_val2  [ENTRIES];
   logic [ROB:0]            r_tag1  [ENTRIES];
   logic [ROB:0]            r_tag2  [ENTRIES];
   logic [ROB:0]            r_rob   [ENTRIES];
   logic [C_WIDTH:0]        r_ctrl  [ENTRIES];
   logic [WIDTH:0]          r_pred  [ENTRIES];
   logic [WIDTH:0]          r_addr  [ENTRIES];
   logic [WIDTH:0]          r_seq   [ENTRIES];
   // r_older[i][j] = 1 when slot i was written before slot j
   logic [ENTRIES-1:0]      r_older [ENTRIES];

   logic                    w_flush;
   logic                    w_do_write;
   logic [IDX_W-1:0]        w_alloc_idx;
   logic [IDX_W-1:0]        w_issue_idx;
   logic                    w_issue_valid;
   logic                    w_do_issue;
   logic [ENTRIES-1:0]      w_m1;
   logic [ENTRIES-1:0]      w_m2;
   logic signed [WIDTH:0]   w_d1    [ENTRIES];
   logic signed [WIDTH:0]   w_d2    [ENTRIES];
   logic [ENTRIES-1:0]      w_req;
   logic [ENTRIES-1:0]      w_sel;
   logic [WIDTH+1:0]        w_lk1   [ENTRIES];
   logic [WIDTH+1:0]        w_lk2   [ENTRIES];
   logic [WIDTH+1:0]        w_bp1;
   logic [WIDTH+1:0]        w_bp2;
   logic [CNT_W-1:0]        w_count;

   // Returns {hit, result}; scanning from the top bus down lets the lowest
   // matching bus index win.
   function automatic logic [WIDTH+1:0] f_cdb_lookup(
      input logic [ROB:0]                   tag,
      input logic [CDB_PORTS-1:0]           vld,
      input logic [CDB_PORTS*(ROB+1)-1:0]   tags,
      input logic [CDB_PORTS*(WIDTH+1)-1:0] res
   );
      logic [WIDTH+1:0] r_hit;
      r_hit = '0;
      for (int k = CDB_PORTS-1; k >= 0; k--) begin
         if (vld[k] && (tags[k*(ROB+1) +: (ROB+1)] == tag))
            r_hit = {1'b1, res[k*(WIDTH+1) +: (WIDTH+1)]};
      end
      return r_hit;
   endfunction

   assign w_flush    = globalReset | (clear & validCommit);
   assign w_do_write = writeReq & ~full & ~w_flush;
   assign w_do_issue = w_issue_valid & issueAccept & ~w_flush;
   assign w_bp1      = f_cdb_lookup(rob1, cdbValid, cdbRob, cdbResult);
   assign w_bp2      = f_cdb_lookup(rob2, cdbValid, cdbRob, cdbResult);

   // Per-slot CDB wakeup and issue request
   always_comb begin
      for (int i = 0; i < ENTRIES; i++) begin
         w_lk1[i] = f_cdb_lookup(r_tag1[i], cdbValid, cdbRob, cdbResult);
         w_lk2[i] = f_cdb_lookup(r_tag2[i], cdbValid, cdbRob, cdbResult);
         w_m1[i]  = ~r_rdy1[i] & w_lk1[i][WIDTH+1];
         w_m2[i]  = ~r_rdy2[i] & w_lk2[i][WIDTH+1];
         w_d1[i]  = w_lk1[i][WIDTH:0];
         w_d2[i]  = w_lk2[i][WIDTH:0];
         w_req[i] = r_busy[i] & (r_rdy1[i] | w_m1[i]) & (r_rdy2[i] | w_m2[i]);
      end
   end

   // Oldest-requester select: a requester is chosen when no other requester is older
   always_comb begin
      w_sel         = '0;
      w_issue_idx   = '0;
      w_issue_valid = 1'b0;
      for (int i = 0; i < ENTRIES; i++) begin
         w_sel[i] = w_req[i];
         for (int j = 0; j < ENTRIES; j++) begin
            if (w_req[j] && r_older[j][i])
               w_sel[i] = 1'b0;
         end
      end
      for (int i = ENTRIES-1; i >= 0; i--) begin
         if (w_sel[i]) begin
            w_issue_idx   = IDX_W'(i);
            w_issue_valid = 1'b1;
         end
      end
   end

   // Lowest free slot for allocation, and occupancy count
   always_comb begin
      w_alloc_idx = '0;
      w_count     = '0;
      for (int i = ENTRIES-1; i >= 0; i--) begin
         if (!r_busy[i])
            w_alloc_idx = IDX_W'(i);
      end
      for (int i = 0; i < ENTRIES; i++)
         w_count = w_count + CNT_W'(r_busy[i]);
   end

   assign full  = &r_busy;
   assign count = w_count;

   // Issue port: idle pattern is all-ones control and zeroed data
   always_comb begin
      issueValid     = w_issue_valid;
      issueRob       = '0;
      issueInfo      = '1;
      issueSrc1      = '0;
      issueSrc2      = '0;
      issuePredicted = '0;
      issueTarget    = '0;
      issueSeq       = '0;
      if (w_issue_valid) begin
         issueRob       = r_rob[w_issue_idx];
         issueInfo      = r_ctrl[w_issue_idx];
         issueSrc1      = w_m1[w_issue_idx] ? w_d1[w_issue_idx] : r_val1[w_issue_idx];
         issueSrc2      = w_m2[w_issue_idx] ? w_d2[w_issue_idx] : r_val2[w_issue_idx];
         issuePredicted = r_pred[w_issue_idx];
         issueTarget    = r_addr[w_issue_idx];
         issueSeq       = r_seq[w_issue_idx];
      end
   end

   // Slot state: flush, CDB capture, issue release, dispatch write and age update
   always_ff @(posedge clk) begin
      if (w_flush) begin
         r_busy <= '0;
         r_rdy1 <= '0;
         r_rdy2 <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            r_val1[i]  <= '0;
            r_val2[i]  <= '0;
            r_tag1[i]  <= '0;
            r_tag2[i]  <= '0;
            r_rob[i]   <= '0;
            r_ctrl[i]  <= '0;
            r_pred[i]  <= '0;
            r_addr[i]  <= '0;
            r_seq[i]   <= '0;
            r_older[i] <= '0;
         end
      end else begin
         for (int i = 0; i < ENTRIES; i++) begin
            if (r_busy[i] && w_m1[i]) begin
               r_val1[i] <= w_d1[i];
               r_rdy1[i] <= 1'b1;
            end
            if (r_busy[i] && w_m2[i]) begin
               r_val2[i] <= w_d2[i];
               r_rdy2[i] <= 1'b1;
            end
            if (w_do_issue && (w_issue_idx == IDX_W'(i)))
               r_busy[i] <= 1'b0;
            if (w_do_write && (w_alloc_idx == IDX_W'(i))) begin
               r_busy[i]  <= 1'b1;
               r_rdy1[i]  <= ready1 | w_bp1[WIDTH+1];
               r_rdy2[i]  <= ready2 | w_bp2[WIDTH+1];
               r_val1[i]  <= (!ready1 && w_bp1[WIDTH+1]) ? w_bp1[WIDTH:0] : value1;
               r_val2[i]  <= (!ready2 && w_bp2[WIDTH+1]) ? w_bp2[WIDTH:0] : value2;
               r_tag1[i]  <= rob1;
               r_tag2[i]  <= rob2;
               r_rob[i]   <= robInstr;
               r_ctrl[i]  <= branchControl;
               r_pred[i]  <= predictedPC;
               r_addr[i]  <= address;
               r_seq[i]   <= seqPC;
               r_older[i] <= '0;
            end
         end
         if (w_do_write) begin
            for (int j = 0; j < ENTRIES; j++) begin
               if (IDX_W'(j) != w_alloc_idx)
                  r_older[j][w_alloc_idx] <= r_busy[j];
            end
         end
      end
   end

endmodule

// File: tb/tb_branch_rs_bank.sv
// Directed bench for branch_rs_bank: reset, age select, CDB wakeup ordering,
// full/drop behaviour, flush and dispatch bypass.
module tb_branch_rs_bank;

   logic               clk;
   logic               globalReset, clear, validCommit, writeReq;
   logic               ready1, ready2;
   logic signed [31:0] value1, value2;
   logic [2:0]         rob1, rob2, robInstr;
   logic [7:0]         branchControl;
   logic [31:0]        predictedPC, address, seqPC;
   logic [1:0]         cdbValid;
   logic [5:0]         cdbRob;
   logic [63:0]        cdbResult;
   logic               issueAccept;
   logic               issueValid;
   logic [2:0]         issueRob;
   logic [7:0]         issueInfo;
   logic signed [31:0] issueSrc1, issueSrc2;
   logic [31:0]        issuePredicted, issueTarget, issueSeq;
   logic               full;
   logic [2:0]         count;

   int n_checks = 0;
   int n_fail   = 0;

   branch_rs_bank dut (
      .clk(clk), .globalReset(globalReset), .clear(clear), .validCommit(validCommit),
      .writeReq(writeReq), .ready1(ready1), .ready2(ready2),
      .value1(value1), .value2(value2), .rob1(rob1), .rob2(rob2),
      .robInstr(robInstr), .branchControl(branchControl),
      .predictedPC(predictedPC), .address(address), .seqPC(seqPC),
      .cdbValid(cdbValid), .cdbRob(cdbRob), .cdbResult(cdbResult),
      .issueAccept(issueAccept), .issueValid(issueValid), .issueRob(issueRob),
      .issueInfo(issueInfo), .issueSrc1(issueSrc1), .issueSrc2(issueSrc2),
      .issuePredicted(issuePredicted), .issueTarget(issueTarget), .issueSeq(issueSeq),
      .full(full), .count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // advance one rising edge, then settle 1 ns past it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      globalReset = 0; clear = 0; validCommit = 0; writeReq = 0;
      ready1 = 0; ready2 = 0; value1 = 0; value2 = 0;
      rob1 = 0; rob2 = 0; robInstr = 0; branchControl = 0;
      predictedPC = 0; address = 0; seqPC = 0;
      cdbValid = 0; cdbRob = 0; cdbResult = 0; issueAccept = 0;
   endtask

   task automatic drive_write(input logic [2:0] rob, input logic r1, input logic signed [31:0] v1,
                              input logic [2:0] t1, input logic r2, input logic signed [31:0] v2,
                              input logic [2:0] t2);
      writeReq = 1; robInstr = rob; branchControl = {5'd0, rob};
      ready1 = r1; value1 = v1; rob1 = t1;
      ready2 = r2; value2 = v2; rob2 = t2;
   endtask

   task automatic test_reset();
      idle_inputs();
      globalReset = 1;
      step();
      globalReset = 0;
      #1;
      n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
      n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %0b exp 0", full); end
      n_checks++; if (issueValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b exp 0", issueValid); end
      n_checks++; if (issueInfo !== 8'hFF) begin n_fail++; $display("FAIL reset_info got %0h exp ff", issueInfo); end
      n_checks++; if (issueRob !== 3'd0 || issueSrc1 !== 0 || issueSeq !== 0) begin
         n_fail++; $display("FAIL reset_idle_fields got rob=%0d src1=%0h seq=%0h exp 0", issueRob, issueSrc1, issueSeq); end
   endtask

   task automatic test_age_select();
      drive_write(3'd1, 1, 32'sd10, 0, 1, 32'sd20, 0);
      step();
      drive_write(3'd2, 1, 32'sd30, 0, 1, 32'sd40, 0);
      #1;
      n_checks++; if (issueValid !== 1'b1 || issueRob !== 3'd1) begin
         n_fail++; $display("FAIL age_first_visible got v=%0b rob=%0d exp v=1 rob=1", issueValid, issueRob); end
      step();
      writeReq = 0;
      #1;
      n_checks++; if (issueRob !== 3'd1 || issueSrc1 !== 32'sd10 || issueSrc2 !== 32'sd20) begin
         n_fail++; $display("FAIL age_oldest got rob=%0d s1=%0d s2=%0d exp rob=1 s1=10 s2=20", issueRob, issueSrc1, issueSrc2); end
      n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL age_count got %0d exp 2", count); end
      issueAccept = 1;
      step();
      issueAccept = 0;
      #1;
      n_checks++; if (issueValid !== 1'b1 || issueRob !== 3'd2 || issueSrc1 !== 32'sd30) begin
         n_fail++; $display("FAIL age_second got v=%0b rob=%0d s1=%0d exp v=1 rob=2 s1=30", issueValid, issueRob, issueSrc1); end
      n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL age_count_after got %0d exp 1", count); end
      issueAccept = 1;
      step();
      issueAccept = 0;
      #1;
      n_checks++; if (count !== 3'd0 || issueValid !== 1'b0) begin
         n_fail++; $display("FAIL age_drain got count=%0d v=%0b exp 0 0", count, issueValid); end
   endtask

   task automatic test_wakeup_order();
      drive_write(3'd3, 0, 32'sd0, 3'd5, 1, 32'sd4, 0);
      step();
      drive_write(3'd4, 1, 32'sd1, 0, 1, 32'sd2, 0);
      step();
      writeReq = 0;
      #1;
      n_checks++; if (issueValid !== 1'b1 || issueRob !== 3'd4) begin
         n_fail++; $display("FAIL wake_only_ready got v=%0b rob=%0d exp v=1 rob=4", issueValid, issueRob); end
      cdbValid = 2'b10; cdbRob = {3'd5, 3'd0}; cdbResult = {32'h1234, 32'h0};
      #1;
      n_checks++; if (issueRob !== 3'd3 || issueSrc1 !== 32'sh1234 || issueSrc2 !== 32'sd4) begin
         n_fail++; $display("FAIL wake_same_cycle got rob=%0d s1=%0h s2=%0d exp rob=3 s1=1234 s2=4", issueRob, issueSrc1, issueSrc2); end
      n_checks++; if (issueInfo !== 8'h03) begin n_fail++; $display("FAIL wake_info got %0h exp 03", issueInfo); end
      issueAccept = 1;
      step();
      cdbValid = 0; cdbRob = 0; cdbResult = 0;
      #1;
      n_checks++; if (issueRob !== 3'd4 || issueSrc1 !== 32'sd1 || count !== 3'd1) begin
         n_fail++; $display("FAIL wake_then_d got rob=%0d s1=%0d count=%0d exp rob=4 s1=1 count=1", issueRob, issueSrc1, count); end
      step();
      issueAccept = 0;
      #1;
      n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL wake_drain got %0d exp 0", count); end
   endtask

   task automatic test_full();
      for (int i = 0; i < 4; i++) begin
         drive_write(3'(i), 1, 32'(i), 0, 1, 32'sd0, 0);
         step();
      end
      n_checks++; if (count !== 3'd4 || full !== 1'b1) begin
         n_fail++; $display("FAIL full_set got count=%0d full=%0b exp 4 1", count, full); end
      drive_write(3'd7, 1, 32'sd77, 0, 1, 32'sd0, 0);
      step();
      writeReq = 0;
      #1;
      n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_drop_count got %0d exp 4", count); end
      n_checks++; if (issueRob !== 3'd0) begin n_fail++; $display("FAIL full_oldest got %0d exp 0", issueRob); end
      issueAccept = 1;
      step();
      issueAccept = 0;
      #1;
      n_checks++; if (count !== 3'd3 || full !== 1'b0) begin
         n_fail++; $display("FAIL full_release got count=%0d full=%0b exp 3 0", count, full); end
      for (int i = 1; i < 4; i++) begin
         n_checks++; if (issueValid !== 1'b1 || issueRob !== 3'(i)) begin
            n_fail++; $display("FAIL full_order got v=%0b rob=%0d exp v=1 rob=%0d", issueValid, issueRob, i); end
         issueAccept = 1;
         step();
         issueAccept = 0;
         #1;
      end
      n_checks++; if (issueValid !== 1'b0 || count !== 3'd0) begin
         n_fail++; $display("FAIL full_dropped_absent got v=%0b count=%0d exp 0 0", issueValid, count); end
   endtask

   task automatic test_flush();
      drive_write(3'd1, 0, 32'sd0, 3'd6, 1, 32'sd0, 0);
      step();
      drive_write(3'd2, 1, 32'sd2, 0, 1, 32'sd0, 0);
      step();
      drive_write(3'd3, 1, 32'sd3, 0, 1, 32'sd0, 0);
      step();
      writeReq = 0;
      clear = 1;
      step();
      clear = 0;
      #1;
      n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL flush_clear_alone got %0d exp 3", count); end
      clear = 1; validCommit = 1; issueAccept = 1;
      cdbValid = 2'b01; cdbRob = {3'd0, 3'd6}; cdbResult = {32'h0, 32'h55};
      drive_write(3'd5, 1, 32'sd5, 0, 1, 32'sd0, 0);
      step();
      idle_inputs();
      #1;
      n_checks++; if (count !== 3'd0 || issueValid !== 1'b0 || full !== 1'b0) begin
         n_fail++; $display("FAIL flush_state got count=%0d v=%0b full=%0b exp 0 0 0", count, issueValid, full); end
      n_checks++; if (issueInfo !== 8'hFF) begin n_fail++; $display("FAIL flush_info got %0h exp ff", issueInfo); end
      cdbValid = 2'b01; cdbRob = {3'd0, 3'd6}; cdbResult = {32'h0, 32'h55};
      step();
      cdbValid = 0;
      step();
      n_checks++; if (issueValid !== 1'b0 || count !== 3'd0) begin
         n_fail++; $display("FAIL flush_stream_empty got v=%0b count=%0d exp 0 0", issueValid, count); end
   endtask

   task automatic test_bypass();
      drive_write(3'd5, 0, 32'sd0, 3'd3, 1, 32'sd9, 0);
      branchControl = 8'h5A; predictedPC = 32'h100; address = 32'h200; seqPC = 32'h104;
      cdbValid = 2'b11; cdbRob = {3'd3, 3'd3}; cdbResult = {32'sd99, -32'sd7};
      #1;
      n_checks++; if (issueValid !== 1'b0) begin n_fail++; $display("FAIL bypass_no_same_cycle got %0b exp 0", issueValid); end
      step();
      idle_inputs();
      #1;
      n_checks++; if (issueValid !== 1'b1 || issueRob !== 3'd5) begin
         n_fail++; $display("FAIL bypass_valid got v=%0b rob=%0d exp v=1 rob=5", issueValid, issueRob); end
      n_checks++; if (issueSrc1 !== -32'sd7 || issueSrc2 !== 32'sd9) begin
         n_fail++; $display("FAIL bypass_src got s1=%0d s2=%0d exp -7 9", issueSrc1, issueSrc2); end
      n_checks++; if (issueInfo !== 8'h5A || issuePredicted !== 32'h100 || issueTarget !== 32'h200 || issueSeq !== 32'h104) begin
         n_fail++; $display("FAIL bypass_fields got info=%0h pred=%0h tgt=%0h seq=%0h exp 5a 100 200 104",
                            issueInfo, issuePredicted, issueTarget, issueSeq); end
      issueAccept = 1;
      step();
      issueAccept = 0;
      #1;
      n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL bypass_drain got %0d exp 0", count); end
   endtask

   task automatic test_back_to_back();
      drive_write(3'd1, 1, 32'sd11, 0, 1, 32'sd0, 0);
      step();
      drive_write(3'd2, 1, 32'sd22, 0, 1, 32'sd0, 0);
      issueAccept = 1;
      step();
      writeReq = 0; issueAccept = 0;
      #1;
      n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL b2b_count got %0d exp 1", count); end
      n_checks++; if (issueRob !== 3'd2 || issueSrc1 !== 32'sd22) begin
         n_fail++; $display("FAIL b2b_next got rob=%0d s1=%0d exp rob=2 s1=22", issueRob, issueSrc1); end
      issueAccept = 1;
      step();
      issueAccept = 0;
      #1;
      n_checks++; if (count !== 3'd0 || issueValid !== 1'b0) begin
         n_fail++; $display("FAIL b2b_drain got count=%0d v=%0b exp 0 0", count, issueValid); end
   endtask

   initial begin
      idle_inputs();
      #2;
      test_reset();
      test_age_select();
      test_wakeup_order();
      test_full();
      test_flush();
      test_bypass();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
